// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: {bout,diff} = a - b - bin, one bit per clock, LSB first.
// Optional signed-overflow output ovf is enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_OVF_EN
  output logic             ovf,
`endif
  output logic             bout
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] res_sr_q, res_sr_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             brw_q, brw_d;
  logic             bout_q, bout_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  logic             cell_d;
  logic             cell_bo;
  logic [WIDTH-1:0] res_next;

  // Full-subtractor bit slice.
  always_comb begin
    cell_d   = a_sr_q[0] ^ b_sr_q[0] ^ brw_q;
    cell_bo  = (~a_sr_q[0] & b_sr_q[0]) | (~(a_sr_q[0] ^ b_sr_q[0]) & brw_q);
    res_next = {cell_d, res_sr_q[WIDTH-1:1]};
  end

  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    res_sr_d = res_sr_q;
    diff_d   = diff_q;
    brw_d    = brw_q;
    bout_d   = bout_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (start) begin
          state_d = StShift;
          a_sr_d  = a;
          b_sr_d  = b;
          brw_d   = bin;
          cnt_d   = '0;
        end
      end
      StShift: begin
        a_sr_d   = {1'b0, a_sr_q[WIDTH-1:1]};
        b_sr_d   = {1'b0, b_sr_q[WIDTH-1:1]};
        res_sr_d = res_next;
        brw_d    = cell_bo;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CntLast) begin
          state_d = StDone;
          diff_d  = res_next;
          bout_d  = cell_bo;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      res_sr_q <= '0;
      diff_q   <= '0;
      brw_q    <= 1'b0;
      bout_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      res_sr_q <= res_sr_d;
      diff_q   <= diff_d;
      brw_q    <= brw_d;
      bout_q   <= bout_d;
      cnt_q    <= cnt_d;
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  logic ovf_q, ovf_d;

  // Borrow into the MSB slice differs from borrow out of it -> signed overflow.
  always_comb begin
    ovf_d = ovf_q;
    if (state_q == StShift && cnt_q == CntLast) begin
      ovf_d = brw_q ^ cell_bo;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

  assign busy = (state_q == StShift);
  assign done = (state_q == StDone);
  assign diff = diff_q;
  assign bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: vector table, corner sequences and random ops
// on WIDTH=2/8/32 instances against an arithmetic reference model.
module tb_serial_subtractor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start2 = 1'b0, start8 = 1'b0, start32 = 1'b0;
  logic [31:0] a_in = '0, b_in = '0;
  logic        bin_in = 1'b0;

  logic        busy2, busy8, busy32;
  logic        done2, done8, done32;
  logic [1:0]  diff2;
  logic [7:0]  diff8;
  logic [31:0] diff32;
  logic        bout2, bout8, bout32;
  logic        ovf2, ovf8, ovf32;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .a(a_in[1:0]), .b(b_in[1:0]), .bin(bin_in),
    .busy(busy2), .done(done2), .diff(diff2),
`ifdef SERIAL_SUB_OVF_EN
    .ovf(ovf2),
`endif
    .bout(bout2)
  );

  serial_subtractor #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a_in[7:0]), .b(b_in[7:0]), .bin(bin_in),
    .busy(busy8), .done(done8), .diff(diff8),
`ifdef SERIAL_SUB_OVF_EN
    .ovf(ovf8),
`endif
    .bout(bout8)
  );

  serial_subtractor #(.WIDTH(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .start(start32), .a(a_in), .b(b_in), .bin(bin_in),
    .busy(busy32), .done(done32), .diff(diff32),
`ifdef SERIAL_SUB_OVF_EN
    .ovf(ovf32),
`endif
    .bout(bout32)
  );

`ifndef SERIAL_SUB_OVF_EN
  assign ovf2  = 1'b0;
  assign ovf8  = 1'b0;
  assign ovf32 = 1'b0;
`endif

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_start(input int w, input logic v);
    case (w)
      2:       start2 = v;
      32:      start32 = v;
      default: start8 = v;
    endcase
  endtask

  function automatic logic get_busy(input int w);
    case (w)
      2:       return busy2;
      32:      return busy32;
      default: return busy8;
    endcase
  endfunction

  function automatic logic get_done(input int w);
    case (w)
      2:       return done2;
      32:      return done32;
      default: return done8;
    endcase
  endfunction

  function automatic logic [31:0] get_diff(input int w);
    case (w)
      2:       return {30'd0, diff2};
      32:      return diff32;
      default: return {24'd0, diff8};
    endcase
  endfunction

  function automatic logic get_bout(input int w);
    case (w)
      2:       return bout2;
      32:      return bout32;
      default: return bout8;
    endcase
  endfunction

  function automatic logic get_ovf(input int w);
    case (w)
      2:       return ovf2;
      32:      return ovf32;
      default: return ovf8;
    endcase
  endfunction

  // Reference model: plain integer arithmetic on the operand values.
  task automatic model(input int w, input logic [31:0] av, input logic [31:0] bv,
                       input logic bi, output logic [31:0] d, output logic bo, output logic ov);
    longint ua, ub, sa, sb, sr, full, lim;
    full = longint'(1) << w;
    lim  = longint'(1) << (w - 1);
    ua = longint'(av);
    ub = longint'(bv);
    bo = (ua < ub + longint'(bi));
    d  = 32'((ua - ub - longint'(bi)) & (full - 1));
    sa = (ua >= lim) ? ua - full : ua;
    sb = (ub >= lim) ? ub - full : ub;
    sr = sa - sb - longint'(bi);
    ov = (sr < -lim) || (sr > lim - 1);
  endtask

  // Called at a negedge; returns the negedge count at which done appeared (0 on timeout).
  task automatic do_op(input int w, input logic [31:0] av, input logic [31:0] bv,
                       input logic bi, output int lat, output int bcnt);
    a_in = av;
    b_in = bv;
    bin_in = bi;
    set_start(w, 1'b1);
    lat = 0;
    bcnt = 0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      set_start(w, 1'b0);
      if (get_busy(w)) bcnt++;
      if (get_done(w)) begin
        lat = k;
        break;
      end
    end
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bi;
    logic [7:0] d;
    logic       bo;
    logic       ov;
  } vec_t;

  initial begin
    vec_t        vecs[8];
    int          lat, bcnt, npulse;
    logic [31:0] md, mask, av, bv;
    logic        mbo, mov, bi;
    int          w;

    vecs[0] = '{8'h35, 8'h12, 1'b0, 8'h23, 1'b0, 1'b0};
    vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[3] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
    vecs[4] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
    vecs[5] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};
    vecs[6] = '{8'h5A, 8'h5A, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[7] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};

    repeat (3) @(negedge clk);
    chk("reset_busy", busy8, 0);
    chk("reset_done", done8, 0);
    chk("reset_diff", diff8, 0);
    chk("reset_bout", bout8, 0);
    chk("reset_ovf", ovf8, 0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      do_op(8, {24'd0, vecs[i].a}, {24'd0, vecs[i].b}, vecs[i].bi, lat, bcnt);
      chk($sformatf("vec%0d_latency", i), lat, 9);
      chk($sformatf("vec%0d_busy_cycles", i), bcnt, 8);
      chk($sformatf("vec%0d_diff", i), diff8, vecs[i].d);
      chk($sformatf("vec%0d_bout", i), bout8, vecs[i].bo);
`ifdef SERIAL_SUB_OVF_EN
      chk($sformatf("vec%0d_ovf", i), ovf8, vecs[i].ov);
`endif
      @(negedge clk);
    end

    // start re-pulsed during SHIFT must be ignored.
    a_in = 32'h35; b_in = 32'h12; bin_in = 1'b0; start8 = 1'b1;
    npulse = 0; lat = 0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      start8 = 1'b0;
      if (done8) begin
        npulse++;
        if (lat == 0) lat = k;
        chk("ignore_diff", diff8, 8'h23);
        chk("ignore_bout", bout8, 0);
      end
      if (k == 3 || k == 5) begin
        a_in = 32'h00; b_in = 32'hFF; bin_in = 1'b1; start8 = 1'b1;
      end
    end
    chk("ignore_latency", lat, 9);
    chk("ignore_pulses", npulse, 1);

    // Back-to-back: start held in DONE with new operands.
    do_op(8, 32'h35, 32'h12, 1'b0, lat, bcnt);
    chk("b2b_first_diff", diff8, 8'h23);
    do_op(8, 32'h10, 32'h20, 1'b0, lat, bcnt);
    chk("b2b_latency", lat, 9);
    chk("b2b_diff", diff8, 8'hF0);
    chk("b2b_bout", bout8, 1);
    @(negedge clk);
    chk("b2b_idle_done", done8, 0);

    // Reset in the middle of SHIFT.
    a_in = 32'h00; b_in = 32'h01; bin_in = 1'b0; start8 = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      start8 = 1'b0;
    end
    chk("midrst_busy_before", busy8, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy8, 0);
    chk("midrst_diff", diff8, 0);
    chk("midrst_bout", bout8, 0);
    npulse = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (k == 2) rst_n = 1'b1;
      if (done8 || busy8) npulse++;
    end
    chk("midrst_no_activity", npulse, 0);
    do_op(8, 32'hA7, 32'h3C, 1'b1, lat, bcnt);
    chk("midrst_next_latency", lat, 9);
    chk("midrst_next_diff", diff8, 8'h6A);
    chk("midrst_next_bout", bout8, 0);
    @(negedge clk);

    // Random operations across all three widths.
    for (int i = 0; i < 1000; i++) begin
      case (i % 3)
        0:       w = 2;
        1:       w = 8;
        default: w = 32;
      endcase
      mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
      av = $urandom & mask;
      bv = $urandom & mask;
      bi = 1'($urandom_range(0, 1));
      if (($urandom % 8) == 0) bv = av;
      model(w, av, bv, bi, md, mbo, mov);
      do_op(w, av, bv, bi, lat, bcnt);
      chk($sformatf("rnd%0d_w%0d_latency", i, w), lat, w + 1);
      chk($sformatf("rnd%0d_w%0d_diff a=%0h b=%0h bin=%0b", i, w, av, bv, bi), get_diff(w), md);
      chk($sformatf("rnd%0d_w%0d_bout", i, w), get_bout(w), mbo);
`ifdef SERIAL_SUB_OVF_EN
      chk($sformatf("rnd%0d_w%0d_ovf", i, w), get_ovf(w), mov);
`else
      if (mov === 1'bx) chk("model_ovf_defined", mov, 0);
`endif
      if ((i % 5) == 0) @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
